regs_bank: RTL and testbench
============================

Name: regs_bank

Overview:
RV32I integer register file; the responder to the decode stage's rs1/rs2 address requests.
- Two combinational read ports feed decode operands.
- One synchronous write port is driven by the execute/writeback stage (rd_addr, reg_wen).
- Write-to-read bypass, x0 hardwired to zero.
- Post-reset sequential scrub FSM, plus a debug read/write port with a one-cycle acknowledge.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W (32 entries)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
rs1_addr_i  input  ADDR_W  read port 1 address (from decode)
rs2_addr_i  input  ADDR_W  read port 2 address (from decode)
rs1_data_o  output  DATA_W  read port 1 data (to decode), combinational
rs2_data_o  output  DATA_W  read port 2 data (to decode), combinational
reg_wen_i  input  1  core write enable (from execute/writeback)
rd_addr_i  input  ADDR_W  core write address
rd_data_i  input  DATA_W  core write data
dbg_req_i  input  1  debug access request, single-cycle pulse
dbg_we_i  input  1  debug access is a write when 1
dbg_addr_i  input  ADDR_W  debug address
dbg_wdata_i  input  DATA_W  debug write data
dbg_ack_o  output  1  debug access complete, one-cycle pulse
dbg_rdata_o  output  DATA_W  debug read data, valid while dbg_ack_o=1
busy_o  output  1  scrub in progress; core must stall fetch/decode

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, sampled at a clock edge:
  - FSM goes to CLEAR, scrub counter is loaded with 1.
  - busy_o=1, dbg_ack_o=0, dbg_rdata_o=0.
  - Array contents are not cleared in that cycle.
- FSM states:
  - CLEAR:
    - Each cycle writes 0 to entry[counter], then counter increments.
    - After entry 31 is written, the next state is RUN (31 cycles in CLEAR).
    - busy_o=1 throughout.
  - RUN: normal operation, busy_o=0.
- Reset asserted mid-CLEAR: counter restarts at 1; the full 31-cycle scrub repeats.
- During CLEAR:
  - rs1_data_o and rs2_data_o read 0.
  - reg_wen_i and dbg_req_i are ignored (no write, no ack).
- Read ports:
  - Address 0 always returns 0.
  - If reg_wen_i=1, rd_addr_i==rsN_addr_i and rd_addr_i!=0, the output is rd_data_i (same-cycle bypass).
  - Otherwise the output is entry[rsN_addr_i].
  - Zero read latency.
- Core write: when reg_wen_i=1 and rd_addr_i!=0, entry[rd_addr_i] <= rd_data_i at the clock edge. Writes to x0 are discarded.
- Debug access:
  - Accepted on dbg_req_i=1 in RUN; dbg_ack_o pulses exactly one cycle later.
  - Debug write with dbg_addr_i!=0: entry[dbg_addr_i] <= dbg_wdata_i at the accept edge.
  - Debug read: dbg_rdata_o latches the pre-edge value of entry[dbg_addr_i] (0 for x0). Debug reads do not use the bypass.
  - For a write, dbg_rdata_o is 0 during ack.
- Core write and debug write in the same cycle:
  - Same nonzero address: the core write wins and the debug write is dropped. dbg_ack_o still pulses.
  - Different addresses: both writes commit. The block is implemented with two write ports.
- dbg_req_i while dbg_ack_o=1: accepted. Back-to-back requests give back-to-back acks.
- Widths: all data paths are DATA_W with no extension; addresses are compared in full ADDR_W.

Decomposition:
- Shared defines file (alongside the instruction-opcode defines): ZERO_WORD (32'b0), ZERO_REG (5'b0), REG_NUM (32), and the FSM state encodings ST_CLEAR and ST_RUN.
- Natural sub-module: regs_bypass, the combinational x0/bypass/array mux. It is instantiated twice, once per read port.

Test Plan:
- Reset for 1 cycle, then release → busy_o=1 for exactly 31 cycles. All 32 entries read 0 afterwards, including entries preloaded with 0xDEADBEEF before reset.
- RUN: write x5=0x12345678. In the same cycle, rs1_addr_i=5 → rs1_data_o=0x12345678 via bypass. Next cycle with reg_wen_i=0 → still 0x12345678.
- Write x0=0xFFFFFFFF with rs2_addr_i=0 → rs2_data_o=0 in the same cycle and afterwards.
- Debug write x7=0xA5A5A5A5, then debug read x7 → dbg_ack_o pulses one cycle after each request, and dbg_rdata_o=0xA5A5A5A5 on the read ack.
- Core write x9=0x1 and debug write x9=0x2 in the same cycle → x9 reads 0x1 and dbg_ack_o pulses. Repeat with debug write to x10=0x2 → x9=0x1 and x10=0x2.
- Assert rst at cycle 10 of CLEAR → busy_o stays high for 31 more cycles; a reg_wen_i/dbg_req_i issued during CLEAR causes no write and no ack.

Source files
------------

// File: rtl/regs_bank_pkg.sv
// regs_bank_pkg: shared constants and FSM encoding for the RV32I register file.
//   ZERO_WORD / ZERO_REG : zero data word and the x0 address
//   REG_NUM              : number of architectural registers
//   NUM_RD               : number of combinational read ports (lanes)
//   state_e              : scrub FSM states (ST_CLEAR, ST_RUN)
package regs_bank_pkg;
  localparam logic [31:0] ZERO_WORD = 32'b0;
  localparam logic [4:0]  ZERO_REG  = 5'b0;
  localparam int          REG_NUM   = 32;
  localparam int          NUM_RD    = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/regs_bank_if.sv
// regs_bank_if: decode read ports, writeback write port and debug port of the
// register file.
//   master : core/debug side (drives addresses, write data, requests)
//   slave  : regs_bank (drives read data, debug ack/rdata, busy)
interface regs_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1_addr_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic [DATA_W-1:0] rs1_data_o;
  logic [DATA_W-1:0] rs2_data_o;
  logic              reg_wen_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_i;
  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_ack_o;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              busy_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, reg_wen_i, rd_addr_i, rd_data_i,
           dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  rs1_data_o, rs2_data_o, dbg_ack_o, dbg_rdata_o, busy_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, reg_wen_i, rd_addr_i, rd_data_i,
           dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output rs1_data_o, rs2_data_o, dbg_ack_o, dbg_rdata_o, busy_o
  );
endinterface

// File: rtl/regs_bypass.sv
// regs_bypass: per-read-port output mux.
//   clr      : scrub in progress, force zero
//   rs_addr  : read address
//   mem_data : array contents at rs_addr
//   wen      : qualified core write (RUN, nonzero rd_addr)
//   rd_addr / rd_data : core write address/data for same-cycle forwarding
//   rs_data  : read result
module regs_bypass
  import regs_bank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wen,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rs_data
);
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(ZERO_REG);
  localparam logic [DATA_W-1:0] ZW = DATA_W'(ZERO_WORD);

  always_comb begin
    rs_data = mem_data;
    if (clr || rs_addr == X0)              rs_data = ZW;
    else if (wen && rd_addr == rs_addr)    rs_data = rd_data;
  end
endmodule

// File: rtl/regs_bank.sv
// regs_bank: RV32I integer register file.
//   clk  : core clock
//   rst  : synchronous active-high reset; starts the post-reset scrub
//   bus  : regs_bank_if.slave -- two combinational read ports with write
//          bypass, one core write port, debug read/write port with a
//          one-cycle ack, busy flag while scrubbing.
// Entry 0 of the array is never written; x0 is produced by the read muxes.
module regs_bank
  import regs_bank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  regs_bank_if.slave bus
);
  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] X0    = ADDR_W'(ZERO_REG);
  localparam logic [DATA_W-1:0] ZW    = DATA_W'(ZERO_WORD);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr, run;

  assign clr = (state_q == ST_CLEAR);
  assign run = (state_q == ST_RUN);

  // Scrub FSM: walks entries 1..DEPTH-1, one per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Write qualification. The bypass sees wr_en; commits are also held off
  // during a reset cycle so reset leaves the array untouched.
  logic wr_en, core_wr, dbg_acc, dbg_wr;

  assign wr_en   = run && bus.reg_wen_i && (bus.rd_addr_i != X0);
  assign core_wr = wr_en && !rst;
  assign dbg_acc = run && bus.dbg_req_i && !rst;
  // Core write wins on a same-address collision; different addresses both land.
  assign dbg_wr  = dbg_acc && bus.dbg_we_i && (bus.dbg_addr_i != X0) &&
                   !(core_wr && bus.rd_addr_i == bus.dbg_addr_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr)     mem[cnt_q]          <= ZW;
      if (dbg_wr)  mem[bus.dbg_addr_i] <= bus.dbg_wdata_i;
      if (core_wr) mem[bus.rd_addr_i]  <= bus.rd_data_i;
    end
  end

  // Debug response: raw array value sampled before the edge, no bypass.
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= ZW;
    end else begin
      dbg_ack_q   <= dbg_acc;
      dbg_rdata_q <= (dbg_acc && !bus.dbg_we_i && bus.dbg_addr_i != X0)
                     ? mem[bus.dbg_addr_i] : ZW;
    end
  end

  assign bus.dbg_ack_o   = dbg_ack_q;
  assign bus.dbg_rdata_o = dbg_rdata_q;
  assign bus.busy_o      = clr;

  // Read lanes.
  logic [NUM_RD-1:0][ADDR_W-1:0] rs_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rs_data;

  assign rs_addr = {bus.rs2_addr_i, bus.rs1_addr_i};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regs_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp (
      .clr      (clr),
      .rs_addr  (rs_addr[g]),
      .mem_data (mem[rs_addr[g]]),
      .wen      (wr_en),
      .rd_addr  (bus.rd_addr_i),
      .rd_data  (bus.rd_data_i),
      .rs_data  (rs_data[g])
    );
  end

  assign bus.rs1_data_o = rs_data[0];
  assign bus.rs2_data_o = rs_data[1];
endmodule

// File: tb/tb_regs_bank.sv
// tb_regs_bank: directed scenarios plus a randomized run against an
// array-based reference model of the register file.
module tb_regs_bank;
  import regs_bank_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regs_bank_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regs_bank #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          vec  = 0;
  int          errs = 0;
  logic [31:0] model [REG_NUM];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
    bus.reg_wen_i = 1'b0; bus.rd_addr_i = '0; bus.rd_data_i = '0;
    bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < REG_NUM; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    idle(); rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 200) begin n++; cyc(); end
    vec++; if (n !== 31) begin errs++; $display("FAIL first_scrub_len: got %0d want 31", n); end
    // preload every entry, then reset again
    for (int i = 1; i < REG_NUM; i++) begin
      bus.reg_wen_i = 1'b1; bus.rd_addr_i = 5'(i); bus.rd_data_i = 32'hDEADBEEF; cyc();
    end
    idle(); rst = 1'b1; cyc(); rst = 1'b0;
    vec++; if (bus.busy_o !== 1'b1) begin errs++; $display("FAIL reset_busy: got %b want 1", bus.busy_o); end
    vec++; if (bus.dbg_ack_o !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b want 0", bus.dbg_ack_o); end
    vec++; if (bus.dbg_rdata_o !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", bus.dbg_rdata_o); end
    bus.rs1_addr_i = 5'd31; bus.rs2_addr_i = 5'd30;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 200) begin
      #3;
      vec++; if (bus.rs1_data_o !== 32'h0 || bus.rs2_data_o !== 32'h0) begin
        errs++; $display("FAIL clear_read: got %h/%h want 0/0", bus.rs1_data_o, bus.rs2_data_o);
      end
      n++; cyc();
    end
    vec++; if (n !== 31) begin errs++; $display("FAIL scrub_len: got %0d want 31", n); end
    clear_model();
    for (int i = 0; i < REG_NUM; i++) begin
      bus.rs1_addr_i = 5'(i); bus.rs2_addr_i = 5'(31 - i); #1;
      vec++; if (bus.rs1_data_o !== 32'h0 || bus.rs2_data_o !== 32'h0) begin
        errs++; $display("FAIL scrubbed_x%0d: got %h/%h want 0/0", i, bus.rs1_data_o, bus.rs2_data_o);
      end
    end
    vec++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL run_busy: got %b want 0", bus.busy_o); end
    idle(); cyc();
  endtask

  task automatic test_bypass();
    bus.reg_wen_i = 1'b1; bus.rd_addr_i = 5'd5; bus.rd_data_i = 32'h12345678; bus.rs1_addr_i = 5'd5;
    #3;
    vec++; if (bus.rs1_data_o !== 32'h12345678) begin errs++; $display("FAIL bypass_same: got %h want 12345678", bus.rs1_data_o); end
    cyc(); bus.reg_wen_i = 1'b0; model[5] = 32'h12345678; #3;
    vec++; if (bus.rs1_data_o !== 32'h12345678) begin errs++; $display("FAIL bypass_next: got %h want 12345678", bus.rs1_data_o); end
    idle(); cyc();
  endtask

  task automatic test_x0();
    bus.reg_wen_i = 1'b1; bus.rd_addr_i = 5'd0; bus.rd_data_i = 32'hFFFFFFFF; bus.rs2_addr_i = 5'd0;
    #3;
    vec++; if (bus.rs2_data_o !== 32'h0) begin errs++; $display("FAIL x0_same: got %h want 0", bus.rs2_data_o); end
    cyc(); bus.reg_wen_i = 1'b0; #3;
    vec++; if (bus.rs2_data_o !== 32'h0) begin errs++; $display("FAIL x0_after: got %h want 0", bus.rs2_data_o); end
    idle(); cyc();
  endtask

  task automatic test_debug();
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b1; bus.dbg_addr_i = 5'd7; bus.dbg_wdata_i = 32'hA5A5A5A5;
    vec++; if (bus.dbg_ack_o !== 1'b0) begin errs++; $display("FAIL dbg_ack_early: got %b want 0", bus.dbg_ack_o); end
    cyc(); model[7] = 32'hA5A5A5A5;
    bus.dbg_we_i = 1'b0; bus.dbg_wdata_i = 32'h0;
    vec++; if (bus.dbg_ack_o !== 1'b1) begin errs++; $display("FAIL dbg_wr_ack: got %b want 1", bus.dbg_ack_o); end
    vec++; if (bus.dbg_rdata_o !== 32'h0) begin errs++; $display("FAIL dbg_wr_rdata: got %h want 0", bus.dbg_rdata_o); end
    cyc(); bus.dbg_req_i = 1'b0;
    vec++; if (bus.dbg_ack_o !== 1'b1) begin errs++; $display("FAIL dbg_rd_ack: got %b want 1", bus.dbg_ack_o); end
    vec++; if (bus.dbg_rdata_o !== 32'hA5A5A5A5) begin errs++; $display("FAIL dbg_rd_data: got %h want a5a5a5a5", bus.dbg_rdata_o); end
    cyc();
    vec++; if (bus.dbg_ack_o !== 1'b0) begin errs++; $display("FAIL dbg_ack_pulse: got %b want 0", bus.dbg_ack_o); end
    idle();
  endtask

  task automatic test_back_to_back();
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 5'd5; cyc();
    bus.dbg_addr_i = 5'd7;
    vec++; if (bus.dbg_ack_o !== 1'b1 || bus.dbg_rdata_o !== model[5]) begin
      errs++; $display("FAIL b2b_first: got %b/%h want 1/%h", bus.dbg_ack_o, bus.dbg_rdata_o, model[5]);
    end
    cyc(); bus.dbg_req_i = 1'b0;
    vec++; if (bus.dbg_ack_o !== 1'b1 || bus.dbg_rdata_o !== model[7]) begin
      errs++; $display("FAIL b2b_second: got %b/%h want 1/%h", bus.dbg_ack_o, bus.dbg_rdata_o, model[7]);
    end
    idle(); cyc();
  endtask

  task automatic test_collision();
    bus.reg_wen_i = 1'b1; bus.rd_addr_i = 5'd9; bus.rd_data_i = 32'h1;
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b1; bus.dbg_addr_i = 5'd9; bus.dbg_wdata_i = 32'h2;
    cyc(); idle(); model[9] = 32'h1;
    vec++; if (bus.dbg_ack_o !== 1'b1) begin errs++; $display("FAIL coll_same_ack: got %b want 1", bus.dbg_ack_o); end
    bus.rs1_addr_i = 5'd9; #1;
    vec++; if (bus.rs1_data_o !== 32'h1) begin errs++; $display("FAIL coll_same_x9: got %h want 1", bus.rs1_data_o); end
    cyc();
    bus.reg_wen_i = 1'b1; bus.rd_addr_i = 5'd9; bus.rd_data_i = 32'h1;
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b1; bus.dbg_addr_i = 5'd10; bus.dbg_wdata_i = 32'h2;
    cyc(); idle(); model[10] = 32'h2;
    vec++; if (bus.dbg_ack_o !== 1'b1) begin errs++; $display("FAIL coll_diff_ack: got %b want 1", bus.dbg_ack_o); end
    bus.rs1_addr_i = 5'd9; bus.rs2_addr_i = 5'd10; #1;
    vec++; if (bus.rs1_data_o !== 32'h1 || bus.rs2_data_o !== 32'h2) begin
      errs++; $display("FAIL coll_diff: got %h/%h want 1/2", bus.rs1_data_o, bus.rs2_data_o);
    end
    idle(); cyc();
  endtask

  task automatic test_mid_clear();
    int n;
    idle(); rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    vec++; if (bus.busy_o !== 1'b1) begin errs++; $display("FAIL mid_busy: got %b want 1", bus.busy_o); end
    rst = 1'b1; cyc(); rst = 1'b0;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 200) begin
      if (n == 20) begin
        bus.reg_wen_i = 1'b1; bus.rd_addr_i = 5'd3; bus.rd_data_i = 32'h55;
        bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b1; bus.dbg_addr_i = 5'd4; bus.dbg_wdata_i = 32'h66;
      end else if (n == 21) begin
        idle();
        vec++; if (bus.dbg_ack_o !== 1'b0) begin errs++; $display("FAIL clear_no_ack: got %b want 0", bus.dbg_ack_o); end
      end
      n++; cyc();
    end
    idle();
    vec++; if (n !== 31) begin errs++; $display("FAIL rescrub_len: got %0d want 31", n); end
    clear_model();
    bus.rs1_addr_i = 5'd3; bus.rs2_addr_i = 5'd4; #1;
    vec++; if (bus.rs1_data_o !== 32'h0 || bus.rs2_data_o !== 32'h0) begin
      errs++; $display("FAIL clear_no_write: got %h/%h want 0/0", bus.rs1_data_o, bus.rs2_data_o);
    end
    idle(); cyc();
  endtask

  task automatic test_random();
    logic        exp_ack = 1'b0;
    logic [31:0] exp_rd  = 32'h0;
    logic [31:0] e1, e2;
    for (int i = 0; i < 400; i++) begin
      vec++; if (bus.dbg_ack_o !== exp_ack) begin errs++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, bus.dbg_ack_o, exp_ack); end
      if (exp_ack) begin
        vec++; if (bus.dbg_rdata_o !== exp_rd) begin errs++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, bus.dbg_rdata_o, exp_rd); end
      end
      bus.reg_wen_i   = 1'($urandom_range(0, 1));
      bus.rd_addr_i   = 5'($urandom_range(0, 31));
      bus.rd_data_i   = $urandom;
      bus.rs1_addr_i  = ($urandom_range(0, 3) == 0) ? bus.rd_addr_i : 5'($urandom_range(0, 31));
      bus.rs2_addr_i  = ($urandom_range(0, 3) == 0) ? bus.rd_addr_i : 5'($urandom_range(0, 31));
      bus.dbg_req_i   = ($urandom_range(0, 2) == 0);
      bus.dbg_we_i    = 1'($urandom_range(0, 1));
      bus.dbg_addr_i  = ($urandom_range(0, 2) == 0) ? bus.rd_addr_i : 5'($urandom_range(0, 31));
      bus.dbg_wdata_i = $urandom;
      #3;
      e1 = model[bus.rs1_addr_i];
      e2 = model[bus.rs2_addr_i];
      if (bus.reg_wen_i && bus.rd_addr_i != 0 && bus.rd_addr_i == bus.rs1_addr_i) e1 = bus.rd_data_i;
      if (bus.reg_wen_i && bus.rd_addr_i != 0 && bus.rd_addr_i == bus.rs2_addr_i) e2 = bus.rd_data_i;
      vec++; if (bus.rs1_data_o !== e1 || bus.rs2_data_o !== e2) begin
        errs++; $display("FAIL rnd_read[%0d]: got %h/%h want %h/%h", i, bus.rs1_data_o, bus.rs2_data_o, e1, e2);
      end
      exp_ack = bus.dbg_req_i;
      exp_rd  = (bus.dbg_req_i && !bus.dbg_we_i) ? model[bus.dbg_addr_i] : 32'h0;
      if (bus.dbg_req_i && bus.dbg_we_i && bus.dbg_addr_i != 0 &&
          !(bus.reg_wen_i && bus.rd_addr_i == bus.dbg_addr_i))
        model[bus.dbg_addr_i] = bus.dbg_wdata_i;
      if (bus.reg_wen_i && bus.rd_addr_i != 0) model[bus.rd_addr_i] = bus.rd_data_i;
      cyc();
    end
    idle();
    vec++; if (bus.dbg_ack_o !== exp_ack) begin errs++; $display("FAIL rnd_ack_last: got %b want %b", bus.dbg_ack_o, exp_ack); end
    for (int i = 0; i < REG_NUM; i++) begin
      bus.rs1_addr_i = 5'(i); #1;
      vec++; if (bus.rs1_data_o !== model[i]) begin errs++; $display("FAIL rnd_final_x%0d: got %h want %h", i, bus.rs1_data_o, model[i]); end
    end
    idle(); cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    clear_model();
    test_reset();
    test_bypass();
    test_x0();
    test_debug();
    test_back_to_back();
    test_collision();
    test_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
